// File: rtl/switch_fabric_param.sv
// Parametrised NIN x NOUT packet switch: per-input FIFOs, one shared transfer
// path chosen by a fixed-priority / round-robin arbiter, per-output FIFOs.

module switch_fabric_param_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    // Fullness/emptiness are judged on the pre-edge count, so a push while
    // full is dropped even when the same edge pops.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    assign rdata = (count == '0) ? '0 : mem[rp];
endmodule

module switch_fabric_param #(
    parameter int W     = 10,
    parameter int NIN   = 4,
    parameter int NOUT  = 4,
    parameter int DEPTH = 8,
    localparam int DW   = $clog2(NOUT),
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int GW   = $clog2(NIN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NIN*W-1:0]  in_data,
    input  logic [NIN-1:0]    in_push,
    output logic [NIN-1:0]    in_full,
    output logic [NIN-1:0]    in_almost_full,
    output logic [NIN-1:0]    in_err,
    input  logic [NOUT-1:0]   out_pop,
    output logic [NOUT*W-1:0] out_data,
    output logic [NOUT-1:0]   out_empty,
    output logic [NOUT-1:0]   out_almost_empty,
    output logic [NOUT-1:0]   out_err,
    input  logic [CW-1:0]     afull_thr,
    input  logic [CW-1:0]     aempty_thr,
    input  logic              mode,
    output logic              grant_valid,
    output logic [GW-1:0]     grant_idx
);
    logic [NIN-1:0][W-1:0]   in_head;
    logic [NIN-1:0][CW-1:0]  in_cnt;
    logic [NIN-1:0]          in_pop;
    logic [NIN-1:0]          elig;
    logic [NOUT-1:0][W-1:0]  out_head;
    logic [NOUT-1:0][CW-1:0] out_cnt;
    logic [NOUT-1:0]         out_push;
    logic [W-1:0]            xfer_word;
    logic [DW-1:0]           xfer_dest;
    logic [GW-1:0]           rr_ptr;

    assign xfer_word = in_head[grant_idx];
    assign xfer_dest = xfer_word[W-1 -: DW];

    for (genvar i = 0; i < NIN; i++) begin : g_in
        logic [DW-1:0] dest;

        switch_fabric_param_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_push[i]),
            .pop   (in_pop[i]),
            .wdata (in_data[i*W +: W]),
            .rdata (in_head[i]),
            .count (in_cnt[i])
        );

        assign dest              = in_head[i][W-1 -: DW];
        assign in_pop[i]         = grant_valid && (grant_idx == GW'(i));
        assign in_full[i]        = (in_cnt[i] == CW'(DEPTH));
        assign in_almost_full[i] = (in_cnt[i] >= afull_thr);
        // Target must be below the programmable threshold and physically not full.
        assign elig[i] = (in_cnt[i] != '0) && (out_cnt[dest] < afull_thr)
                         && (out_cnt[dest] != CW'(DEPTH));
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
        switch_fabric_param_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (out_push[j]),
            .pop   (out_pop[j]),
            .wdata (xfer_word),
            .rdata (out_head[j]),
            .count (out_cnt[j])
        );

        assign out_push[j]          = grant_valid && (xfer_dest == DW'(j));
        assign out_data[j*W +: W]   = out_head[j];
        assign out_empty[j]         = (out_cnt[j] == '0);
        assign out_almost_empty[j]  = (out_cnt[j] <= aempty_thr);
    end

    // Scan in reverse so the last hit is the first candidate in search order.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NIN - 1; k >= 0; k--) begin
            if (mode) begin
                if (elig[(int'(rr_ptr) + k) % NIN]) begin
                    grant_valid = 1'b1;
                    grant_idx   = GW'((int'(rr_ptr) + k) % NIN);
                end
            end else if (elig[k]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_err  <= '0;
            out_err <= '0;
            rr_ptr  <= '0;
        end else begin
            in_err  <= in_err | (in_push & in_full);
            out_err <= out_err | (out_pop & out_empty);
            if (grant_valid && mode)
                rr_ptr <= (grant_idx == GW'(NIN - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_switch_fabric_param.sv
// Random + directed bench for switch_fabric_param against a queue-based model.

module tb_switch_fabric_param;
    localparam int W = 10, NIN = 4, NOUT = 4, DEPTH = 8;
    localparam int DW = 2, CW = 4, GW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NIN*W-1:0]  in_data = '0;
    logic [NIN-1:0]    in_push = '0;
    logic [NIN-1:0]    in_full, in_almost_full, in_err;
    logic [NOUT-1:0]   out_pop = '0;
    logic [NOUT*W-1:0] out_data;
    logic [NOUT-1:0]   out_empty, out_almost_empty, out_err;
    logic [CW-1:0]     afull_thr = 4'd8;
    logic [CW-1:0]     aempty_thr = 4'd2;
    logic              mode = 1'b0;
    logic              grant_valid;
    logic [GW-1:0]     grant_idx;

    always #5 clk = ~clk;

    switch_fabric_param #(.W(W), .NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_push(in_push), .in_full(in_full),
        .in_almost_full(in_almost_full), .in_err(in_err),
        .out_pop(out_pop), .out_data(out_data), .out_empty(out_empty),
        .out_almost_empty(out_almost_empty), .out_err(out_err),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .mode(mode),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    logic [W-1:0]    iq [NIN][$];
    logic [W-1:0]    oq [NOUT][$];
    logic [NIN-1:0]  m_in_err;
    logic [NOUT-1:0] m_out_err;
    int              m_rr;
    int              checks = 0, failures = 0;
    logic            obs_gv;
    int              obs_gi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void m_grant(output logic gv, output int g);
        gv = 1'b0;
        g  = 0;
        for (int k = 0; k < NIN; k++) begin
            int i, d;
            logic [W-1:0] h;
            i = mode ? (m_rr + k) % NIN : k;
            if (!gv && iq[i].size() > 0) begin
                h = iq[i][0];
                d = int'(h[W-1 -: DW]);
                if (oq[d].size() < int'(afull_thr) && oq[d].size() < DEPTH) begin
                    gv = 1'b1;
                    g  = i;
                end
            end
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NIN; i++) iq[i].delete();
        for (int j = 0; j < NOUT; j++) oq[j].delete();
        m_in_err  = '0;
        m_out_err = '0;
        m_rr      = 0;
    endtask

    task automatic check_all();
        logic gv;
        int   g;
        logic [NIN-1:0]    ef, eaf;
        logic [NOUT-1:0]   ee, eae;
        logic [NOUT*W-1:0] ed;
        m_grant(gv, g);
        ed = '0;
        for (int i = 0; i < NIN; i++) begin
            ef[i]  = (iq[i].size() == DEPTH);
            eaf[i] = (iq[i].size() >= int'(afull_thr));
        end
        for (int j = 0; j < NOUT; j++) begin
            ee[j]  = (oq[j].size() == 0);
            eae[j] = (oq[j].size() <= int'(aempty_thr));
            if (!ee[j]) ed[j*W +: W] = oq[j][0];
        end
        chk("grant_valid", grant_valid, gv);
        chk("grant_idx", grant_idx, gv ? g : 0);
        chk("in_full", in_full, ef);
        chk("in_almost_full", in_almost_full, eaf);
        chk("in_err", in_err, m_in_err);
        chk("out_empty", out_empty, ee);
        chk("out_almost_empty", out_almost_empty, eae);
        chk("out_data", out_data, ed);
        chk("out_err", out_err, m_out_err);
    endtask

    task automatic model_edge();
        logic gv;
        int   g;
        logic [NIN-1:0]  pre_full;
        logic [NOUT-1:0] pre_empty;
        logic [W-1:0]    w;
        m_grant(gv, g);
        for (int i = 0; i < NIN; i++) pre_full[i] = (iq[i].size() == DEPTH);
        for (int j = 0; j < NOUT; j++) pre_empty[j] = (oq[j].size() == 0);
        for (int j = 0; j < NOUT; j++)
            if (out_pop[j]) begin
                if (pre_empty[j]) m_out_err[j] = 1'b1;
                else w = oq[j].pop_front();
            end
        if (gv) begin
            w = iq[g].pop_front();
            oq[int'(w[W-1 -: DW])].push_back(w);
            if (mode) m_rr = (g + 1) % NIN;
        end
        for (int i = 0; i < NIN; i++)
            if (in_push[i]) begin
                if (pre_full[i]) m_in_err[i] = 1'b1;
                else iq[i].push_back(in_data[i*W +: W]);
            end
    endtask

    // One clock: compare at negedge, advance model at posedge, release strobes.
    task automatic cycle();
        @(negedge clk);
        check_all();
        obs_gv = grant_valid;
        obs_gi = int'(grant_idx);
        @(posedge clk);
        model_edge();
        #1;
        in_push = '0;
        out_pop = '0;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        in_push = '0;
        out_pop = '0;
        #1;
        chk("rst_out_empty", out_empty, 4'b1111);
        chk("rst_in_full", in_full, 4'b0000);
        chk("rst_in_err", in_err, 4'b0000);
        chk("rst_out_err", out_err, 4'b0000);
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_out_data", out_data, 40'h0);
        chk("rst_out_aempty", out_almost_empty, 4'b1111);
        chk("rst_in_afull", in_almost_full, (afull_thr == 0) ? 4'b1111 : 4'b0000);
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_word(input int ch, input logic [W-1:0] w);
        in_data[ch*W +: W] = w;
        in_push[ch] = 1'b1;
    endtask

    initial begin
        int ngr;
        int exp_rr [4];
        logic [W-1:0] wa, wb, wc;
        exp_rr = '{2, 3, 0, 1};

        apply_reset();

        // Routing: 0x305 to output 3
        push_word(0, 10'h305);
        cycle();
        cycle();
        chk("route_gv", obs_gv, 1'b1);
        chk("route_gi", obs_gi, 0);
        chk("route_data3", out_data[3*W +: W], 10'h305);
        chk("route_empty", out_empty, 4'b0111);

        // Fixed priority
        apply_reset();
        for (int i = 0; i < NIN; i++) push_word(i, {i[1:0], 8'hA0} + 10'(i));
        cycle();
        for (int k = 0; k < NIN; k++) begin
            cycle();
            chk("fixed_gv", obs_gv, 1'b1);
            chk("fixed_order", obs_gi, k);
        end

        // Round robin starting after a grant to input 1
        apply_reset();
        mode = 1'b1;
        push_word(1, 10'h011);
        cycle();
        cycle();
        chk("rr_seed_gi", obs_gi, 1);
        for (int i = 0; i < NIN; i++) push_word(i, {i[1:0], 8'hB0} + 10'(i));
        cycle();
        for (int k = 0; k < NIN; k++) begin
            cycle();
            chk("rr_gv", obs_gv, 1'b1);
            chk("rr_order", obs_gi, exp_rr[k]);
        end
        mode = 1'b0;

        // Backpressure on output 2
        apply_reset();
        afull_thr  = 4'd3;
        aempty_thr = 4'd2;
        ngr = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) push_word(1, 10'h200 + 10'(k));
            cycle();
            ngr += int'(obs_gv);
        end
        chk("bp_transfers", ngr, 3);
        chk("bp_aempty2", out_almost_empty[2], 1'b0);
        out_pop[2] = 1'b1;
        cycle();
        chk("bp_pop_cycle_gv", obs_gv, 1'b0);
        cycle();
        chk("bp_after_pop_gv", obs_gv, 1'b1);

        // Full and push error on input 2
        apply_reset();
        afull_thr = 4'd0;
        for (int k = 0; k < 9; k++) begin
            push_word(2, 10'h280 + 10'(k));
            cycle();
            if (k == 7) begin
                chk("full_in_full2", in_full[2], 1'b1);
                chk("full_in_err_pre", in_err[2], 1'b0);
            end
        end
        chk("full_in_err2", in_err[2], 1'b1);
        chk("full_afull2", in_almost_full[2], 1'b1);

        // Empty pop, then simultaneous write+pop on output 1
        apply_reset();
        afull_thr  = 4'd8;
        aempty_thr = 4'd1;
        out_pop[0] = 1'b1;
        cycle();
        chk("empty_pop_err0", out_err[0], 1'b1);
        wa = 10'h111; wb = 10'h122; wc = 10'h133;
        push_word(0, wa); cycle();
        push_word(0, wb); cycle();
        cycle();
        chk("sim_pre_aempty1", out_almost_empty[1], 1'b0);
        push_word(0, wc); cycle();
        out_pop[1] = 1'b1;
        cycle();
        chk("sim_xfer_gv", obs_gv, 1'b1);
        chk("sim_head1", out_data[1*W +: W], wb);
        chk("sim_aempty1", out_almost_empty[1], 1'b0);

        // Randomised traffic with occasional mid-stream resets
        apply_reset();
        for (int n = 0; n < 1200; n++) begin
            if (n % 300 == 299) apply_reset();
            if (n % 60 == 0) begin
                mode       = 1'($urandom);
                afull_thr  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 3))
                                                         : CW'($urandom_range(4, 8));
                aempty_thr = CW'($urandom_range(0, 8));
            end
            for (int i = 0; i < NIN; i++) begin
                in_data[i*W +: W] = W'($urandom);
                in_push[i] = ($urandom_range(0, 99) < 35);
            end
            for (int j = 0; j < NOUT; j++) out_pop[j] = ($urandom_range(0, 99) < 30);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
